my_module_cond: RTL and testbench



---
 rtl/elev_pkg.sv | 17 +
 rtl/bit_sync.sv | 25 ++
 rtl/my_module_cond.sv | 78 +++++++
 tb/tb_my_module_cond.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared definitions for the elevator-queue front end: default button
// conditioner constants and the per-button event record consumed by the
// request queue.
package elev_pkg;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 4;

   // One button's conditioned view, as seen by the request queue.
   typedef struct packed {
      logic level;    // debounced level
      logic rise;     // one-cycle pulse on level 0->1
      logic fall;     // one-cycle pulse on level 1->0
      logic pending;  // sticky request, cleared by the queue
   } btn_evt_t;

endpackage

// File: rtl/bit_sync.sv
// Generic multi-flop synchroniser for a single asynchronous bit.
// Ports: clk, rst_n (async active-low, clears chain to 0), d (async input),
//        q (synchronised output, SYNC_STAGES cycles behind d).
module bit_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
      end
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/my_module_cond.sv
// Call-button conditioner: synchronise, debounce, edge-detect and latch a
// sticky request for the queue logic.
// Ports: clk, rst_n (async active-low), my_input (raw button), my_clear
//        (queue acknowledge), my_output (clean level), my_rise / my_fall
//        (one-cycle edge pulses), my_pending (sticky request flag).
module my_module_cond
   import elev_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic my_input,
   input  logic my_clear,
   output logic my_output,
   output logic my_rise,
   output logic my_fall,
   output logic my_pending
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s_in;
   logic [CNT_W-1:0] cnt;
   btn_evt_t         evt;
   logic             flip;

   // The synchroniser is the only reader of the raw input.
   bit_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (my_input),
      .q     (s_in)
   );

   // s_in has differed from the level for DEBOUNCE_CYCLES consecutive
   // cycles including this one: accept it on this edge.
   assign flip = (s_in != evt.level) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         evt <= '0;
      end else begin
         evt.rise <= flip & s_in;
         evt.fall <= flip & ~s_in;

         // Any agreement restarts the stable window; saturates at the
         // flip so the counter never wraps.
         if ((s_in == evt.level) || flip) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         if (flip) begin
            evt.level <= s_in;
         end

         // A new press beats a simultaneous acknowledge so it is never lost.
         if (flip && s_in) begin
            evt.pending <= 1'b1;
         end else if (my_clear) begin
            evt.pending <= 1'b0;
         end
      end
   end

   assign my_output  = evt.level;
   assign my_rise    = evt.rise;
   assign my_fall    = evt.fall;
   assign my_pending = evt.pending;

endmodule

// File: tb/tb_my_module_cond.sv
// Self-checking bench for my_module_cond: default instance plus a
// SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 instance, scoreboarded edge events.
module tb_my_module_cond;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a_in = 1'b0, a_clr = 1'b0;
   logic a_out, a_rise, a_fall, a_pend;
   logic b_in = 1'b0, b_clr = 1'b0;
   logic b_out, b_rise, b_fall, b_pend;

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   localparam logic [1:0] K_RISE = 2'b10;
   localparam logic [1:0] K_FALL = 2'b01;

   typedef struct {
      int         dut;
      int         edge_no;
      logic [1:0] kind;
   } exp_evt_t;

   exp_evt_t sb[$];

   my_module_cond u_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .my_input   (a_in),
      .my_clear   (a_clr),
      .my_output  (a_out),
      .my_rise    (a_rise),
      .my_fall    (a_fall),
      .my_pending (a_pend)
   );

   my_module_cond #(
      .SYNC_STAGES     (3),
      .DEBOUNCE_CYCLES (1)
   ) u_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .my_input   (b_in),
      .my_clear   (b_clr),
      .my_output  (b_out),
      .my_rise    (b_rise),
      .my_fall    (b_fall),
      .my_pending (b_pend)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Expect an edge pulse 'lat' rising edges after the current one.
   task automatic expect_evt(input int dut, input int lat, input logic [1:0] kind);
      exp_evt_t e;
      e.dut     = dut;
      e.edge_no = cyc + lat;
      e.kind    = kind;
      sb.push_back(e);
   endtask

   // Monitor: every pulse must match the oldest expected event in dut,
   // edge number and kind; an expected event whose edge passes is missed.
   always @(negedge clk) begin : monitor
      logic [1:0] p [2];
      exp_evt_t   e;
      if (mon_en) begin
         p[0] = {a_rise, a_fall};
         p[1] = {b_rise, b_fall};
         for (int d = 0; d < 2; d++) begin
            if (p[d] != 2'b00) begin
               if (sb.size() == 0) begin
                  chk("unexpected_pulse", 32'(p[d]), 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("evt_dut", d, e.dut);
                  chk("evt_edge", cyc, e.edge_no);
                  chk("evt_kind", 32'(p[d]), 32'(e.kind));
               end
            end
         end
         if (sb.size() > 0 && sb[0].edge_no < cyc) begin
            chk("missed_evt", cyc, sb[0].edge_no);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      // Reset state
      tick(2);
      chk("rst_a", {a_out, a_rise, a_fall, a_pend}, 4'b0000);
      chk("rst_b", {b_out, b_rise, b_fall, b_pend}, 4'b0000);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Idle with inputs held low
      for (int i = 0; i < 100; i++) begin
         tick(1);
         chk("idle_a", {a_out, a_rise, a_fall, a_pend}, 4'b0000);
         chk("idle_b", {b_out, b_rise, b_fall, b_pend}, 4'b0000);
      end

      // Clear with nothing pending is a no-op
      a_clr = 1'b1;
      tick(1);
      a_clr = 1'b0;
      tick(1);
      chk("clr_noop_pend", a_pend, 1'b0);

      // Press: rise 6 edges after the drive point
      a_in = 1'b1;
      expect_evt(0, 6, K_RISE);
      tick(10);
      chk("press_level", a_out, 1'b1);
      chk("press_pend", a_pend, 1'b1);

      // Release: fall, pending untouched
      a_in = 1'b0;
      expect_evt(0, 6, K_FALL);
      tick(10);
      chk("release_level", a_out, 1'b0);
      chk("release_pend", a_pend, 1'b1);

      // Pending still set; clear sampled on the same edge as a new rise
      a_in = 1'b1;
      expect_evt(0, 6, K_RISE);
      tick(5);
      a_clr = 1'b1;
      tick(1);
      a_clr = 1'b0;
      chk("set_wins_pend", a_pend, 1'b1);
      chk("set_wins_rise", a_rise, 1'b1);
      tick(1);
      chk("set_wins_hold", a_pend, 1'b1);

      // Plain acknowledge
      a_clr = 1'b1;
      tick(1);
      a_clr = 1'b0;
      chk("clear_pend", a_pend, 1'b0);

      // Fall does not set pending
      a_in = 1'b0;
      expect_evt(0, 6, K_FALL);
      tick(10);
      chk("fall_no_pend", a_pend, 1'b0);

      // Glitches of 1 and 3 cycles are rejected
      a_in = 1'b1;
      tick(1);
      a_in = 1'b0;
      tick(10);
      chk("glitch1_level", a_out, 1'b0);
      a_in = 1'b1;
      tick(3);
      a_in = 1'b0;
      tick(10);
      chk("glitch3_level", a_out, 1'b0);
      chk("glitch_pend", a_pend, 1'b0);

      // SYNC_STAGES=3, DEBOUNCE_CYCLES=1: 4-edge latency
      b_in = 1'b1;
      expect_evt(1, 4, K_RISE);
      tick(8);
      chk("b_press_level", b_out, 1'b1);
      chk("b_press_pend", b_pend, 1'b1);
      b_in = 1'b0;
      expect_evt(1, 4, K_FALL);
      tick(8);
      chk("b_release_level", b_out, 1'b0);

      // Reset in the middle of a debounce window (counter at 2)
      a_in = 1'b1;
      expect_evt(0, 6, K_RISE);
      tick(4);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_a", {a_out, a_rise, a_fall, a_pend}, 4'b0000);
      chk("midrst_b_pend", b_pend, 1'b0);
      tick(3);
      rst_n = 1'b1;
      expect_evt(0, 6, K_RISE);
      tick(10);
      chk("postrst_level", a_out, 1'b1);
      chk("postrst_pend", a_pend, 1'b1);

      tick(5);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
